// File: rtl/glitc_train_pkg.sv
// Shared constants and FSM state type for the GLITC training sequencer.
package glitc_train_pkg;

  localparam logic [3:0] DPTRAINING_ADDR = 4'd2;

  // Field positions inside the DPTRAINING register.
  localparam int BITSLIP_BIT = 30;
  localparam int DISABLE_BIT = 31;
  localparam int SELECT_MSB  = 22;
  localparam int SELECT_LSB  = 16;
  localparam int PATTERN_MSB = 7;
  localparam int PATTERN_LSB = 0;

  localparam int NUM_CHANNELS = 6;
  localparam int NUM_BITS     = 12;
  localparam int NUM_TOTAL    = NUM_CHANNELS * NUM_BITS;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    SETTLE,
    READ,
    COMPARE,
    SLIP,
    NEXT,
    DONE
  } state_t;

endpackage

// File: rtl/glitc_train_settle_timer.sv
// Loadable down-counter with a zero flag; it holds at zero once it gets there.
module glitc_train_settle_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             zero
);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/glitc_train_sequencer.sv
// Sweeps all 72 datapath bits, bitslipping each one until DPTRAINING reads back the training word.
// Define TRAIN_FAIL_MASK_EN to build the per-bit fail_mask_o register; otherwise it reads as zero.
module glitc_train_sequencer
  import glitc_train_pkg::*;
#(
  parameter logic [7:0] TRAIN_PATTERN = 8'hA5,
  parameter int         SETTLE_CYCLES = 16,
  parameter int         MAX_SLIP      = 8
) (
  input  logic        user_clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        abort_i,
  output logic        user_sel_o,
  output logic        user_wr_o,
  output logic [3:0]  user_addr_o,
  output logic [31:0] user_dat_o,
  input  logic [31:0] user_dat_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [6:0]  fail_count_o,
  output logic [71:0] fail_mask_o
);

  localparam int TIMER_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] SETTLE_LOAD =
    (SETTLE_CYCLES > 0) ? TIMER_W'(SETTLE_CYCLES - 1) : '0;
  localparam int SLIP_W = (MAX_SLIP > 0) ? $clog2(MAX_SLIP + 1) : 1;
  localparam logic [6:0] TOTAL_BITS = 7'(NUM_TOTAL);

  state_t            state_reg, state_next;
  logic [2:0]        ch_reg;
  logic [3:0]        bit_reg;
  logic [SLIP_W-1:0] slip_reg;
  logic [7:0]        word_reg;
  logic [6:0]        fail_count_reg;
  logic [6:0]        bit_sel;
  logic              settle_zero, settle_load;
  logic              last_bit, word_match, slip_left, start_accept, bit_fail;
  logic              unused_dat_hi;

  assign bit_sel      = {ch_reg, bit_reg};
  assign last_bit     = (ch_reg == 3'(NUM_CHANNELS - 1)) && (bit_reg == 4'(NUM_BITS - 1));
  assign word_match   = (word_reg == TRAIN_PATTERN);
  assign slip_left    = (slip_reg < SLIP_W'(MAX_SLIP));
  assign start_accept = (state_reg == IDLE) && start_i && !abort_i;
  assign bit_fail     = (state_reg == COMPARE) && !word_match && !slip_left;
  assign settle_load  = (state_reg == SELECT) || (state_reg == SLIP);
  assign unused_dat_hi = ^user_dat_i[31:PATTERN_MSB+1];

  // The timer is loaded on every register write so SETTLE lasts exactly SETTLE_CYCLES cycles.
  glitc_train_settle_timer #(
    .WIDTH(TIMER_W)
  ) u_settle_timer (
    .clk       (user_clk_i),
    .rst       (rst_i),
    .load      (settle_load),
    .load_value(SETTLE_LOAD),
    .zero      (settle_zero)
  );

  always_ff @(posedge user_clk_i or posedge rst_i) begin
    if (rst_i) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next  = state_reg;
    user_sel_o  = 1'b0;
    user_wr_o   = 1'b0;
    user_addr_o = '0;
    user_dat_o  = '0;
    case (state_reg)
      IDLE:    if (start_accept) state_next = SELECT;
      SELECT: begin
        user_sel_o  = 1'b1;
        user_wr_o   = 1'b1;
        user_addr_o = DPTRAINING_ADDR;
        user_dat_o[SELECT_MSB:SELECT_LSB] = bit_sel;
        state_next  = SETTLE;
      end
      SETTLE:  if (settle_zero) state_next = READ;
      READ: begin
        user_sel_o  = 1'b1;
        user_addr_o = DPTRAINING_ADDR;
        state_next  = COMPARE;
      end
      COMPARE: state_next = (!word_match && slip_left) ? SLIP : NEXT;
      SLIP: begin
        user_sel_o  = 1'b1;
        user_wr_o   = 1'b1;
        user_addr_o = DPTRAINING_ADDR;
        user_dat_o[BITSLIP_BIT] = 1'b1;
        user_dat_o[SELECT_MSB:SELECT_LSB] = bit_sel;
        state_next  = SETTLE;
      end
      NEXT:    state_next = last_bit ? DONE : SELECT;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    // The bus cycle driven above still completes; only the successor is overridden.
    if (abort_i && (state_reg != IDLE)) state_next = IDLE;
  end

  always_ff @(posedge user_clk_i or posedge rst_i) begin
    if (rst_i) begin
      ch_reg         <= '0;
      bit_reg        <= '0;
      slip_reg       <= '0;
      word_reg       <= '0;
      fail_count_reg <= '0;
    end else begin
      if (start_accept) begin
        ch_reg         <= '0;
        bit_reg        <= '0;
        slip_reg       <= '0;
        word_reg       <= '0;
        fail_count_reg <= '0;
      end
      if (state_reg == READ) word_reg <= user_dat_i[PATTERN_MSB:PATTERN_LSB];
      if (state_reg == SLIP) slip_reg <= slip_reg + 1'b1;
      if (state_reg == NEXT) begin
        slip_reg <= '0;
        if (bit_reg == 4'(NUM_BITS - 1)) begin
          if (!last_bit) begin
            bit_reg <= '0;
            ch_reg  <= ch_reg + 1'b1;
          end
        end else begin
          bit_reg <= bit_reg + 1'b1;
        end
      end
      if (bit_fail && (fail_count_reg != TOTAL_BITS)) fail_count_reg <= fail_count_reg + 1'b1;
    end
  end

`ifdef TRAIN_FAIL_MASK_EN
  logic [NUM_TOTAL-1:0] fail_mask_reg;
  logic [6:0]           fail_idx;

  assign fail_idx = 7'(ch_reg) * 7'(NUM_BITS) + 7'(bit_reg);

  always_ff @(posedge user_clk_i or posedge rst_i) begin
    if (rst_i)             fail_mask_reg <= '0;
    else if (start_accept) fail_mask_reg <= '0;
    else if (bit_fail)     fail_mask_reg[fail_idx] <= 1'b1;
  end

  assign fail_mask_o = fail_mask_reg;
`else
  assign fail_mask_o = '0;
`endif

  assign busy_o       = (state_reg != IDLE);
  assign done_o       = (state_reg == DONE);
  assign fail_count_o = fail_count_reg;

endmodule

// File: tb/tb_glitc_train_sequencer.sv
// Self-checking bench: a register-bus model answers DPTRAINING reads, and a sweep model predicts writes, timing and failures.
module tb_glitc_train_sequencer;
  localparam int         SETTLE = 16;
  localparam int         MAXS   = 8;
  localparam logic [7:0] PAT    = 8'hA5;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        sel, wr, busy, done;
  logic [3:0]  addr;
  logic [31:0] dat_o, dat_i;
  logic [6:0]  fcnt;
  logic [71:0] fmask;

  glitc_train_sequencer #(
    .TRAIN_PATTERN(PAT), .SETTLE_CYCLES(SETTLE), .MAX_SLIP(MAXS)
  ) dut (
    .user_clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort),
    .user_sel_o(sel), .user_wr_o(wr), .user_addr_o(addr), .user_dat_o(dat_o),
    .user_dat_i(dat_i), .busy_o(busy), .done_o(done),
    .fail_count_o(fcnt), .fail_mask_o(fmask)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input bit ok, input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Bus model: req[i] is how many bitslips bit i needs before it reads back the pattern.
  int          req [72];
  logic [7:0]  bad [72];
  logic [6:0]  cur_sel   = '0;
  int          cur_slips = 0;
  logic [23:0] noise     = '0;

  always @(posedge clk) begin
    noise <= 24'($urandom);
    if (sel && wr) begin
      if (dat_o[30]) cur_slips <= cur_slips + 1;
      else begin
        cur_sel   <= dat_o[22:16];
        cur_slips <= 0;
      end
    end
  end

  function automatic logic [7:0] respond(input logic [6:0] s, input int slips);
    int idx;
    idx = int'(s[6:4]) * 12 + int'(s[3:0]);
    if (idx >= 72 || s[3:0] >= 4'd12) return 8'h00;
    return (slips >= req[idx]) ? PAT : bad[idx];
  endfunction

  assign dat_i = {noise, respond(cur_sel, cur_slips)};

  // Sweep model: the writes it must see in order, cycles spent busy, and the failures.
  logic [31:0] exp_wr [$];
  int          exp_busy, exp_fail, exp_slips;
  logic [71:0] exp_mask;

  task automatic build_model();
    exp_wr.delete();
    exp_busy  = 1;
    exp_fail  = 0;
    exp_slips = 0;
    exp_mask  = '0;
    for (int ch = 0; ch < 6; ch++) begin
      for (int b = 0; b < 12; b++) begin
        int idx;
        int n;
        logic [6:0] s;
        idx = ch * 12 + b;
        s   = {3'(ch), 4'(b)};
        n   = (req[idx] > MAXS) ? MAXS : req[idx];
        exp_wr.push_back({9'b0, s, 16'b0});
        for (int k = 0; k < n; k++) exp_wr.push_back({2'b01, 7'b0, s, 16'b0});
        exp_busy  += (SETTLE + 4) + n * (SETTLE + 3);
        exp_slips += n;
        if (req[idx] > MAXS) begin
          exp_fail++;
          exp_mask[idx] = 1'b1;
        end
      end
    end
`ifndef TRAIN_FAIL_MASK_EN
    exp_mask = '0;
`endif
  endtask

  // Compare process: bus legality and write order every cycle, plus event counters.
  int          done_cnt = 0, busy_cnt = 0, slip_cnt = 0, bus_cnt = 0, read_cnt = 0;
  logic [31:0] last_wr = '0, last_slip = '0, mon_exp;

  initial forever begin
    @(negedge clk);
    if (!sel) begin
      check(!wr && addr == 4'd0 && dat_o == 32'd0, "bus_idle_zero", 72'({wr, addr, dat_o}), 72'(0));
    end else begin
      bus_cnt++;
      if (wr) begin
        last_wr = dat_o;
        if (dat_o[30]) begin
          slip_cnt++;
          last_slip = dat_o;
        end
        if (exp_wr.size() == 0) begin
          check(1'b0, "unexpected_write", 72'(dat_o), 72'(0));
        end else begin
          mon_exp = exp_wr.pop_front();
          check(addr == 4'd2 && dat_o == mon_exp, "write_seq", 72'({addr, dat_o}), 72'({4'd2, mon_exp}));
        end
      end else begin
        read_cnt++;
        check(addr == 4'd2 && dat_o == 32'd0, "read_cycle", 72'({addr, dat_o}), 72'({4'd2, 32'd0}));
      end
    end
    if (done) done_cnt++;
    if (busy) busy_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic run_sweep(input string name, input bit poke);
    int d0, b0, s0, i;
    bit seen;
    build_model();
    d0 = done_cnt;
    b0 = busy_cnt;
    s0 = slip_cnt;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    check(busy == 1'b1, {name, ":start_accepted"}, 72'(busy), 72'(1));
    check(fcnt == 7'd0, {name, ":count_cleared"}, 72'(fcnt), 72'(0));
    check(fmask == 72'd0, {name, ":mask_cleared"}, fmask, 72'(0));
    seen = 1'b0;
    for (i = 0; i < 20000 && !seen; i++) begin
      start = poke && (i % 400 == 200);
      tick(1);
      if (done_cnt != d0) seen = 1'b1;
    end
    start = 1'b0;
    if (!seen) check(1'b0, {name, ":done_timeout"}, 72'(i), 72'(20000));
    tick(3);
    check(done_cnt - d0 == 1, {name, ":done_pulses"}, 72'(done_cnt - d0), 72'(1));
    check(exp_wr.size() == 0, {name, ":writes_left"}, 72'(exp_wr.size()), 72'(0));
    check(busy_cnt - b0 == exp_busy, {name, ":busy_cycles"}, 72'(busy_cnt - b0), 72'(exp_busy));
    check(slip_cnt - s0 == exp_slips, {name, ":slip_writes"}, 72'(slip_cnt - s0), 72'(exp_slips));
    check(fcnt == 7'(exp_fail), {name, ":fail_count"}, 72'(fcnt), 72'(exp_fail));
    check(fmask == exp_mask, {name, ":fail_mask"}, fmask, exp_mask);
    check(busy == 1'b0, {name, ":idle_after"}, 72'(busy), 72'(0));
  endtask

  initial begin
    int d0, bc, i;
    bit found;
    for (int k = 0; k < 72; k++) begin
      req[k] = 0;
      bad[k] = 8'h5A;
    end
    tick(2);
    check({busy, done, sel, wr, addr, dat_o, fcnt} == 46'd0, "reset_outputs", 72'({busy, done, sel, wr, addr, dat_o, fcnt}), 72'(0));
    check(fmask == 72'd0, "reset_mask", fmask, 72'(0));
    rst = 1'b0;

    // The sweep model itself, pinned to hand-computed values.
    build_model();
    check(exp_wr[0] == 32'h0000_0000, "model_first_select", 72'(exp_wr[0]), 72'(32'h0000_0000));
    check(exp_wr[71] == 32'h005B_0000, "model_last_select", 72'(exp_wr[71]), 72'(32'h005B_0000));
    check(exp_busy == 1441, "model_busy_cycles", 72'(exp_busy), 72'(1441));
    run_sweep("all_match", 1'b0);

    for (int k = 0; k < 72; k++) begin
      do bad[k] = 8'($urandom); while (bad[k] == PAT);
    end

    req[31] = 3;
    run_sweep("slip3_ch2b7", 1'b0);
    check(last_slip == 32'h4027_0000, "slip_dat_ch2b7", 72'(last_slip), 72'(32'h4027_0000));
    check(fcnt == 7'd0, "slip3_no_fail", 72'(fcnt), 72'(0));

    req[31] = 0;
    req[71] = 255;
    run_sweep("never_ch5b11", 1'b0);
    check(fcnt == 7'd1, "never_fail_count", 72'(fcnt), 72'(1));
`ifdef TRAIN_FAIL_MASK_EN
    check(fmask[71] == 1'b1, "never_mask71", 72'(fmask[71]), 72'(1));
`else
    check(fmask[71] == 1'b0, "never_mask71", 72'(fmask[71]), 72'(0));
`endif

    for (int k = 0; k < 72; k++) req[k] = ($urandom_range(0, 99) < 85) ? 0 : int'($urandom_range(1, 12));
    run_sweep("random_poke", 1'b1);

    // Abort during SETTLE of ch1/bit0.
    for (int k = 0; k < 72; k++) req[k] = 0;
    build_model();
    start = 1'b1;
    tick(1);
    start = 1'b0;
    found = 1'b0;
    for (i = 0; i < 3000 && !found; i++) begin
      tick(1);
      if (last_wr == 32'h0010_0000) found = 1'b1;
    end
    check(found, "abort_reached_ch1", 72'(last_wr), 72'(32'h0010_0000));
    tick(3);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    exp_wr.delete();
    check(busy == 1'b0, "abort_idle", 72'(busy), 72'(0));
    d0 = done_cnt;
    bc = bus_cnt;
    tick(60);
    check(done_cnt == d0, "abort_no_done", 72'(done_cnt - d0), 72'(0));
    check(bus_cnt == bc, "abort_no_bus", 72'(bus_cnt - bc), 72'(0));

    // abort and start together in IDLE: nothing starts.
    start = 1'b1;
    abort = 1'b1;
    tick(1);
    start = 1'b0;
    abort = 1'b0;
    check(busy == 1'b0, "abort_beats_start", 72'(busy), 72'(0));
    bc = bus_cnt;
    tick(5);
    check(bus_cnt == bc, "abort_start_no_bus", 72'(bus_cnt - bc), 72'(0));

    // Reset in the middle of a READ cycle.
    build_model();
    start = 1'b1;
    tick(1);
    start = 1'b0;
    d0 = read_cnt;
    found = 1'b0;
    for (i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (sel && !wr && read_cnt - d0 >= 4) found = 1'b1;
    end
    check(found, "reset_read_reached", 72'(read_cnt - d0), 72'(5));
    #1 rst = 1'b1;
    #1;
    check({busy, done, sel, wr, addr, dat_o, fcnt} == 46'd0, "async_reset_outputs", 72'({busy, done, sel, wr, addr, dat_o, fcnt}), 72'(0));
    check(fmask == 72'd0, "async_reset_mask", fmask, 72'(0));
    exp_wr.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_sweep("after_reset", 1'b0);

    // Every bit fails: fail_count_o reaches its ceiling of 72.
    for (int k = 0; k < 72; k++) req[k] = 255;
    run_sweep("all_fail", 1'b0);
    check(fcnt == 7'd72, "all_fail_count", 72'(fcnt), 72'(72));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
